// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [3:0] except_instr_addr_misaligned = 4'd0;
  localparam logic [3:0] except_instr_access_fault    = 4'd1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // One buffered halfword; fault marks a halfword that came from a faulting access.
  typedef struct packed {
    logic        fault;
    logic [15:0] data;
  } hw_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exception;
    logic [3:0]  ecause;
    logic [31:0] etval;
  } fetch_out_type;

  // Compressed (16-bit) encodings have low bits other than 2'b11.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Halfword FIFO between the memory response and the realigner.
// Accepts 0..2 halfwords and releases 0..2 halfwords per cycle.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic [1:0]    i_push_num,
  input  hw_entry_t     i_push0,
  input  hw_entry_t     i_push1,
  input  logic [1:0]    i_pop_num,
  output logic [CW-1:0] o_count,
  output hw_entry_t     o_head0,
  output hw_entry_t     o_head1
);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wr_ptr1;
  hw_entry_t     w_slots [DEPTH];

  assign w_wr_ptr1 = r_wr_ptr + PW'(1);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    hw_entry_t r_slot;
    // First pushed halfword lands at the tail, the second one slot after it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_slot <= '0;
      end else if (!i_flush) begin
        if (i_push_num != 2'd0 && r_wr_ptr == PW'(gi)) begin
          r_slot <= i_push0;
        end else if (i_push_num == 2'd2 && w_wr_ptr1 == PW'(gi)) begin
          r_slot <= i_push1;
        end
      end
    end
    assign w_slots[gi] = r_slot;
  end

  // Pointers wrap naturally at DEPTH; count tracks push minus pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push_num);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop_num);
      r_count  <= r_count + CW'(i_push_num) - CW'(i_pop_num);
    end
  end

  assign o_count = r_count;
  assign o_head0 = w_slots[r_rd_ptr];
  assign o_head1 = w_slots[r_rd_ptr + PW'(1)];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: word requests to imem, halfword buffering, RVC
// realignment, redirect flushing and fetch-fault reporting.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_exception,
  output logic [3:0]  f_ecause,
  output logic [31:0] f_etval
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_fault_addr;
  logic [31:0]   r_mis_addr;
  logic          r_skip_low;
  logic          r_drop;
  logic          r_mis;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  hw_entry_t     w_head0;
  hw_entry_t     w_head1;
  hw_entry_t     w_push0;
  hw_entry_t     w_push1;
  logic [1:0]    w_push_num;
  logic [1:0]    w_pop_num;
  logic [31:0]   w_pc_step;
  logic          w_req;
  logic          w_hs;
  logic          w_accept;
  logic [31:0]   w_req_addr;
  fetch_out_type w_out;

  // A new request needs two free slots; an outstanding one already reserved them.
  assign w_free     = CW'(BUF_DEPTH) - w_count;
  assign w_req      = !rst && ((r_state == ST_RUN && w_free >= CW'(2)) || r_state == ST_WAIT);
  assign w_req_addr = (r_state == ST_WAIT) ? r_req_addr : r_fetch_addr;
  assign w_hs       = w_req && imem_ready;
  assign w_accept   = w_hs && !redirect && !r_drop;
  assign w_pc_step  = {29'd0, w_pop_num, 1'b0};

  // Turn an accepted response into halfword pushes (or a single fault marker).
  always_comb begin
    w_push_num = 2'd0;
    w_push0    = '0;
    w_push1    = '0;
    if (w_accept) begin
      if (imem_error) begin
        w_push_num    = 2'd1;
        w_push0.fault = 1'b1;
      end else if (r_skip_low) begin
        w_push_num   = 2'd1;
        w_push0.data = imem_rdata[31:16];
      end else begin
        w_push_num   = 2'd2;
        w_push0.data = imem_rdata[15:0];
        w_push1.data = imem_rdata[31:16];
      end
    end
  end

  // Realign the buffer head into one instruction slot and decide how much it consumes.
  always_comb begin
    w_out     = '0;
    w_pop_num = 2'd0;
    w_out.pc  = r_pc;
    if (r_mis) begin
      w_out.valid     = 1'b1;
      w_out.exception = 1'b1;
      w_out.ecause    = except_instr_addr_misaligned;
      w_out.etval     = r_mis_addr;
    end else if (w_count >= CW'(1) && w_head0.fault) begin
      w_out.valid     = 1'b1;
      w_out.exception = 1'b1;
      w_out.ecause    = except_instr_access_fault;
      w_out.etval     = r_fault_addr;
    end else if (w_count >= CW'(1) && is_rvc(w_head0.data)) begin
      w_out.valid = 1'b1;
      w_out.instr = {16'h0000, w_head0.data};
      w_pop_num   = 2'd1;
    end else if (w_count >= CW'(2) && w_head1.fault) begin
      w_out.valid     = 1'b1;
      w_out.exception = 1'b1;
      w_out.ecause    = except_instr_access_fault;
      w_out.etval     = r_fault_addr;
    end else if (w_count >= CW'(2)) begin
      w_out.valid = 1'b1;
      w_out.instr = {w_head1.data, w_head0.data};
      w_pop_num   = 2'd2;
    end
    if (!w_out.valid || stall || redirect) begin
      w_pop_num = 2'd0;
    end
    if (!w_out.valid) begin
      w_out.pc = 32'h0;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect),
    .i_push_num (w_push_num),
    .i_push0    (w_push0),
    .i_push1    (w_push1),
    .i_pop_num  (w_pop_num),
    .o_count    (w_count),
    .o_head0    (w_head0),
    .o_head1    (w_head1)
  );

  // Request FSM plus PC / fetch-address / drop bookkeeping; redirect wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC & ~32'h3;
      r_req_addr   <= 32'h0;
      r_fault_addr <= 32'h0;
      r_mis_addr   <= 32'h0;
      r_skip_low   <= RESET_PC[1];
      r_drop       <= 1'b0;
      r_mis        <= 1'b0;
    end else if (redirect) begin
      r_pc         <= redirect_addr;
      r_fetch_addr <= {redirect_addr[31:2], 2'b00};
      r_skip_low   <= redirect_addr[1];
      r_mis        <= redirect_addr[0];
      r_mis_addr   <= redirect_addr;
      if (w_req && !imem_ready) begin
        // The old request must still complete on the bus; its data is thrown away.
        r_state    <= ST_WAIT;
        r_req_addr <= w_req_addr;
        r_drop     <= 1'b1;
      end else begin
        r_state <= redirect_addr[0] ? ST_FAULT : ST_RUN;
        r_drop  <= 1'b0;
      end
    end else begin
      r_pc <= r_pc + w_pc_step;
      case (r_state)
        ST_RUN: begin
          if (w_req && !imem_ready) begin
            r_state    <= ST_WAIT;
            r_req_addr <= r_fetch_addr;
          end
        end
        ST_WAIT: begin
          if (imem_ready) begin
            r_state <= ST_RUN;
          end
        end
        default: ;
      endcase
      if (w_hs) begin
        if (r_drop) begin
          r_drop  <= 1'b0;
          r_state <= r_mis ? ST_FAULT : ST_RUN;
        end else if (imem_error) begin
          r_state      <= ST_FAULT;
          r_fault_addr <= w_req_addr;
        end else begin
          r_fetch_addr <= r_fetch_addr + 32'd4;
          r_skip_low   <= 1'b0;
        end
      end
    end
  end

  assign imem_valid  = w_req;
  assign imem_addr   = rst ? 32'h0 : w_req_addr;
  assign f_valid     = w_out.valid;
  assign f_pc        = w_out.pc;
  assign f_instr     = w_out.instr;
  assign f_exception = w_out.exception;
  assign f_ecause    = w_out.ecause;
  assign f_etval     = w_out.etval;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: word memory responder, an instruction-stream
// reference model checked every cycle, and directed scenario checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        stall = 1'b0;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_exception;
  logic [3:0]  f_ecause;
  logic [31:0] f_etval;

  logic [31:0] mem [0:255];
  logic        ready_en = 1'b1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;

  int total = 0;
  int bad = 0;

  logic [63:0] seen [$];
  logic [31:0] hs_addr [$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .BUF_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_valid    (imem_valid),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .imem_error    (imem_error),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .stall         (stall),
    .f_valid       (f_valid),
    .f_pc          (f_pc),
    .f_instr       (f_instr),
    .f_exception   (f_exception),
    .f_ecause      (f_ecause),
    .f_etval       (f_etval)
  );

  // Memory answers in the request cycle whenever ready_en allows it.
  assign imem_ready = imem_valid && ready_en;
  assign imem_rdata = mem[imem_addr[9:2]];
  assign imem_error = err_en && (imem_addr == err_addr);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return err_en && ((a & ~32'h3) == err_addr);
  endfunction

  // What the decode stage must see for the instruction starting at pc:
  // {pc, instr, exception, ecause, etval}.
  function automatic logic [100:0] expect_at(input logic [31:0] pc, input logic mis);
    logic [15:0] lo;
    logic [15:0] hi;
    logic [31:0] pc2;
    pc2 = pc + 32'd2;
    if (mis) return {pc, 32'h0, 1'b1, 4'd0, pc};
    if (is_err(pc)) return {pc, 32'h0, 1'b1, 4'd1, pc & ~32'h3};
    lo = hw_at(pc);
    if (lo[1:0] != 2'b11) return {pc, 16'h0, lo, 1'b0, 4'd0, 32'h0};
    if (is_err(pc2)) return {pc, 32'h0, 1'b1, 4'd1, pc2 & ~32'h3};
    hi = hw_at(pc2);
    return {pc, hi, lo, 1'b0, 4'd0, 32'h0};
  endfunction

  // Reference model: expected PC stream advanced by consumes and redirects.
  logic [31:0]  m_pc = 32'h0;
  logic         m_mis = 1'b0;
  logic         prev_hold = 1'b0;
  logic         prev_wait = 1'b0;
  logic [100:0] prev_out = '0;
  logic [31:0]  prev_addr = 32'h0;

  always @(negedge clk) begin
    logic [100:0] act_v;
    logic [100:0] raw_v;
    logic [100:0] exp_v;
    logic [15:0]  lo;
    if (rst) begin
      m_pc      = 32'h0;
      m_mis     = 1'b0;
      prev_hold = 1'b0;
      prev_wait = 1'b0;
    end else begin
      raw_v = {f_pc, f_instr, f_exception, f_ecause, f_etval};
      act_v = raw_v;
      if (prev_hold) chk("stall_hold", raw_v, prev_out);
      if (prev_wait) chk("req_stable", {imem_valid, imem_addr}, {1'b1, prev_addr});
      if (!f_exception) chk("no_exc_zero", {f_ecause, f_etval}, 36'h0);
      if (f_valid) begin
        exp_v = expect_at(m_pc, m_mis);
        if (exp_v[36]) act_v[68:37] = 32'h0;
        chk("model", act_v, exp_v);
      end
      prev_hold = f_valid && stall && !redirect;
      prev_out  = raw_v;
      prev_wait = imem_valid && !imem_ready;
      prev_addr = imem_addr;
      if (redirect) begin
        m_pc  = redirect_addr;
        m_mis = redirect_addr[0];
      end else if (f_valid && !stall && !f_exception) begin
        lo   = hw_at(m_pc);
        m_pc = m_pc + ((lo[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
    end
  end

  // Transaction log: handshakes and consumed instructions.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_valid && imem_ready) hs_addr.push_back(imem_addr);
      if (f_valid && !f_exception && !stall && !redirect) begin
        seen.push_back({f_pc, f_instr});
        $display("instr pc=%08h instr=%08h", f_pc, f_instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_test();
    rst = 1'b1;
    redirect = 1'b0;
    stall = 1'b0;
    err_en = 1'b0;
    ready_en = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    tick();
  endtask

  task automatic end_reset();
    tick();
    @(negedge clk);
    chk("reset_outs", {imem_valid, imem_addr, f_valid, f_pc, f_instr, f_exception, f_ecause, f_etval}, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen.delete();
    hs_addr.delete();
  endtask

  task automatic chk_seen(input string name, input int idx, input logic [31:0] pc, input logic [31:0] instr);
    logic [63:0] v;
    v = (idx < seen.size()) ? seen[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
    chk(name, v, {pc, instr});
  endtask

  task automatic chk_hs(input string name, input int idx, input logic [31:0] a);
    logic [31:0] v;
    v = (idx < hs_addr.size()) ? hs_addr[idx] : 32'hFFFF_FFFF;
    chk(name, v, a);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    seen.delete();
    hs_addr.delete();
    redirect = 1'b1;
    redirect_addr = a;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    logic found;

    // T1: 32-bit NOP stream from reset
    begin_test();
    end_reset();
    repeat (8) tick();
    chk_seen("t1_i0", 0, 32'h0, 32'h0000_0013);
    chk_seen("t1_i1", 1, 32'h4, 32'h0000_0013);
    chk_seen("t1_i2", 2, 32'h8, 32'h0000_0013);
    chk_hs("t1_a0", 0, 32'h0);
    chk_hs("t1_a1", 1, 32'h4);
    chk_hs("t1_a2", 2, 32'h8);

    // T2: two compressed instructions in one word
    begin_test();
    mem[0] = 32'h4501_4505;
    end_reset();
    repeat (8) tick();
    chk_seen("t2_i0", 0, 32'h0, 32'h0000_4505);
    chk_seen("t2_i1", 1, 32'h2, 32'h0000_4501);
    chk_seen("t2_i2", 2, 32'h4, 32'h0000_0013);

    // T3: 32-bit instruction straddling words 0 and 4
    begin_test();
    mem[0] = 32'h0513_4505;
    mem[1] = 32'h0013_00A0;
    end_reset();
    tick();
    ready_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t3_wait", {f_valid, imem_valid, imem_addr}, {1'b0, 1'b1, 32'h4});
    @(posedge clk);
    #1;
    ready_en = 1'b1;
    repeat (4) tick();
    chk_seen("t3_i0", 0, 32'h0, 32'h0000_4505);
    chk_seen("t3_i1", 1, 32'h2, 32'h00A0_0513);

    // T4: redirect to 0x102 while the request to 8 is outstanding
    begin_test();
    mem[2]  = 32'h1111_1111;
    mem[64] = 32'h4501_0001;
    end_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_valid && imem_addr == 32'h8) begin
        ready_en = 1'b0;
        found = 1'b1;
      end else begin
        ready_en = 1'b1;
        tick();
      end
    end
    chk("t4_req8", found, 1'b1);
    repeat (2) tick();
    do_redirect(32'h0000_0102);
    tick();
    ready_en = 1'b1;
    repeat (8) tick();
    chk_hs("t4_drop8", 0, 32'h8);
    chk_hs("t4_req100", 1, 32'h100);
    chk_seen("t4_i0", 0, 32'h102, 32'h0000_4501);
    chk_seen("t4_i1", 1, 32'h104, 32'h0000_0013);

    // T5: access fault on the fetch to 0x200, then recovery via redirect to 0x300
    begin_test();
    end_reset();
    repeat (3) tick();
    err_en = 1'b1;
    err_addr = 32'h200;
    do_redirect(32'h0000_01F8);
    repeat (10) tick();
    chk_seen("t5_i0", 0, 32'h1F8, 32'h0000_0013);
    chk_seen("t5_i1", 1, 32'h1FC, 32'h0000_0013);
    @(negedge clk);
    chk("t5_fault", {f_valid, f_exception, f_ecause, f_etval, f_pc}, {1'b1, 1'b1, 4'd1, 32'h200, 32'h200});
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nv += int'(imem_valid);
    end
    chk("t5_no_req", nv, 0);
    @(posedge clk);
    #1;
    do_redirect(32'h0000_0300);
    repeat (6) tick();
    chk_seen("t5_resume", 0, 32'h300, 32'h0000_0013);
    @(negedge clk);
    chk("t5_no_exc", f_exception, 1'b0);

    // T6: stall holds the slot, then a misaligned redirect
    begin_test();
    end_reset();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_hold", {f_valid, f_pc, f_instr}, {1'b1, 32'h0, 32'h0000_0013});
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    tick();
    chk_seen("t6_after", 0, 32'h0, 32'h0000_0013);
    do_redirect(32'h0000_0101);
    repeat (2) tick();
    @(negedge clk);
    chk("t6_misaligned", {f_valid, f_exception, f_ecause, f_etval, f_pc}, {1'b1, 1'b1, 4'd0, 32'h101, 32'h101});
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nv += int'(imem_valid);
    end
    chk("t6_no_req", nv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
